imm_ext_arbiter: RTL and testbench

Shares the single 12→32 sign-extension unit between two immediate requesters: decode (port 0) and the load/store address unit (port 1). Each requester presents a raw 32-bit RV32I instruction. The block performs four steps:
- arbitrates round-robin between the two ports;
- selects and packs the 12-bit immediate field for the instruction format;
- drives the shared extender;
- returns the registered 32-bit immediate through a valid/ready output stage.

It sits between the decode/LSU front ends and the extender instance in the datapath.

---
 rtl/imm_ext_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_imm_ext_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter: shares one 12->32 sign extender between decode (port 0) and the LSU (port 1).
// Build option: define IMM_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module imm_ext_arbiter #(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    input  logic [31:0]      req0_instr,
    input  logic [TAG_W-1:0] req0_tag,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [31:0]      req1_instr,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             req1_ready,
    output logic [11:0]      ext_in,
    input  logic [31:0]      ext_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_imm,
    output logic             res_src,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned IMM_W = 12;
    localparam int unsigned OP_W  = 7;

    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        FMT_I    = 2'd0,
        FMT_S    = 2'd1,
        FMT_B    = 2'd2,
        FMT_NONE = 2'd3
    } fmt_t;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic             src;
        logic [TAG_W-1:0] tag;
        logic             err;
    } res_t;

    state_t state_q, state_d;
    res_t   res_q, res_d;

    logic             free_c;
    logic             grant0_c;
    logic             grant1_c;
    logic             accept_c;
    logic [XLEN-1:0]  sel_instr_c;
    logic [TAG_W-1:0] sel_tag_c;
    fmt_t             fmt_c;
    logic [XLEN-1:0]  imm_c;
    logic             unused_instr_bits;

    // Result register can take new data when empty or being drained this cycle.
    assign free_c = ~res_valid | res_ready;

`ifdef IMM_ARB_FIXED_PRIO_EN
    // Port 0 always wins; port 1 only sees the extender when decode is idle.
    assign grant0_c = req0_valid;
    assign grant1_c = req1_valid & ~req0_valid;
`else
    logic last_q;

    // last_q = 1 means port 1 was served most recently, so port 0 wins next contention.
    assign grant0_c = req0_valid & (~req1_valid | last_q);
    assign grant1_c = req1_valid & (~req0_valid | ~last_q);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else if (accept_c) begin
            last_q <= grant1_c;
        end
    end
`endif

    assign req0_ready = reset_n & grant0_c & free_c;
    assign req1_ready = reset_n & grant1_c & free_c;
    assign accept_c   = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    // Granted port's request; zero when nobody holds the grant.
    always_comb begin
        sel_instr_c = '0;
        sel_tag_c   = '0;
        if (grant1_c) begin
            sel_instr_c = req1_instr;
            sel_tag_c   = req1_tag;
        end else if (grant0_c) begin
            sel_instr_c = req0_instr;
            sel_tag_c   = req0_tag;
        end
    end

    // Bits 19:12 never carry a 12-bit immediate field.
    assign unused_instr_bits = ^sel_instr_c[19:12];

    // Pack the 12-bit immediate field for the extender.
    always_comb begin
        fmt_c  = FMT_NONE;
        ext_in = '0;
        case (sel_instr_c[OP_W-1:0])
            OP_LOAD, OP_IMM, OP_JALR: begin
                fmt_c  = FMT_I;
                ext_in = sel_instr_c[31:20];
            end
            OP_STORE: begin
                fmt_c  = FMT_S;
                ext_in = {sel_instr_c[31:25], sel_instr_c[11:7]};
            end
            OP_BRANCH: begin
                fmt_c  = FMT_B;
                ext_in = {sel_instr_c[31], sel_instr_c[7], sel_instr_c[30:25], sel_instr_c[11:8]};
            end
            default: begin
                fmt_c  = FMT_NONE;
                ext_in = IMM_W'(0);
            end
        endcase
    end

    // Branch offsets are in halfwords; the extender's bit 30 already replicates the sign.
    always_comb begin
        imm_c = '0;
        case (fmt_c)
            FMT_I, FMT_S: imm_c = ext_out;
            FMT_B:        imm_c = {ext_out[XLEN-2:0], 1'b0};
            default:      imm_c = '0;
        endcase
    end

    always_comb begin
        res_d     = res_q;
        res_d.imm = imm_c;
        res_d.src = grant1_c;
        res_d.tag = sel_tag_c;
        res_d.err = (fmt_c == FMT_NONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Accept always wins over drain so a same-cycle drain+accept stays FULL.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_c) state_d = ST_FULL;
            end
            ST_FULL: begin
                if (accept_c) begin
                    state_d = ST_FULL;
                end else if (res_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            res_q <= '0;
        end else if (accept_c) begin
            res_q <= res_d;
        end
    end

    assign res_valid = (state_q == ST_FULL);
    assign res_imm   = res_q.imm;
    assign res_src   = res_q.src;
    assign res_tag   = res_q.tag;
    assign res_err   = res_q.err;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// tb_imm_ext_arbiter: directed and randomized checks of imm_ext_arbiter against a behavioural model.
// Honors IMM_ARB_FIXED_PRIO_EN for the expected arbitration order.
module tb_imm_ext_arbiter;
    localparam int unsigned TAG_W = 4;

    logic             clk;
    logic             reset_n;
    logic             req0_valid;
    logic [31:0]      req0_instr;
    logic [TAG_W-1:0] req0_tag;
    logic             req0_ready;
    logic             req1_valid;
    logic [31:0]      req1_instr;
    logic [TAG_W-1:0] req1_tag;
    logic             req1_ready;
    logic [11:0]      ext_in;
    logic [31:0]      ext_out;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_imm;
    logic             res_src;
    logic [TAG_W-1:0] res_tag;
    logic             res_err;

    // Shared extender sitting outside the arbiter.
    assign ext_out = {{20{ext_in[11]}}, ext_in};

    imm_ext_arbiter #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_instr (req0_instr),
        .req0_tag   (req0_tag),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_instr (req1_instr),
        .req1_tag   (req1_tag),
        .req1_ready (req1_ready),
        .ext_in     (ext_in),
        .ext_out    (ext_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_imm    (res_imm),
        .res_src    (res_src),
        .res_tag    (res_tag),
        .res_err    (res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // Reference state: the result register contents and the most recently served port.
    logic             m_valid;
    logic             m_show;
    logic [31:0]      m_imm;
    logic             m_src;
    logic [TAG_W-1:0] m_tag;
    logic             m_err;
    int               m_last;
    logic             acc0;
    logic             acc1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Immediate value from the ISA definition, as signed integer arithmetic; bit 32 = no-immediate flag.
    function automatic logic [32:0] ref_imm(input logic [31:0] ins);
        int v;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67: begin
                v = int'(ins[31:20]);
                if (v >= 2048) v = v - 4096;
                return {1'b0, 32'(v)};
            end
            7'h23: begin
                v = int'({ins[31:25], ins[11:7]});
                if (v >= 2048) v = v - 4096;
                return {1'b0, 32'(v)};
            end
            7'h63: begin
                v = int'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
                if (v >= 4096) v = v - 8192;
                return {1'b0, 32'(v)};
            end
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    function automatic logic [11:0] ref_field(input logic [31:0] ins);
        case (ins[6:0])
            7'h03, 7'h13, 7'h67: return ins[31:20];
            7'h23:               return {ins[31:25], ins[11:7]};
            7'h63:               return {ins[31], ins[7], ins[30:25], ins[11:8]};
            default:             return 12'h000;
        endcase
    endfunction

    function automatic int ref_winner();
        if (req0_valid && req1_valid) begin
`ifdef IMM_ARB_FIXED_PRIO_EN
            return 0;
`else
            return 1 - m_last;
`endif
        end
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    // One clock: check outputs at negedge, then advance the model across the posedge.
    task automatic cycle();
        int          w;
        logic        fr;
        logic        e0;
        logic        e1;
        logic [31:0] gi;
        logic [32:0] r;
        @(negedge clk);
        w  = ref_winner();
        fr = !m_valid || res_ready;
        e0 = reset_n && (w == 0) && fr;
        e1 = reset_n && (w == 1) && fr;
        check("req0_ready", 32'(req0_ready), 32'(e0));
        check("req1_ready", 32'(req1_ready), 32'(e1));
        check("res_valid", 32'(res_valid), 32'(m_valid));
        if (m_valid || m_show) begin
            check("res_imm", res_imm, m_imm);
            check("res_src", 32'(res_src), 32'(m_src));
            check("res_tag", 32'(res_tag), 32'(m_tag));
            check("res_err", 32'(res_err), 32'(m_err));
        end
        if (reset_n) begin
            gi = (w == 1) ? req1_instr : ((w == 0) ? req0_instr : 32'h0);
            check("ext_in", 32'(ext_in), 32'(ref_field(gi)));
        end
        @(posedge clk);
        acc0 = req0_valid && e0;
        acc1 = req1_valid && e1;
        if (!reset_n) begin
            m_valid = 1'b0;
            m_imm   = '0;
            m_src   = 1'b0;
            m_tag   = '0;
            m_err   = 1'b0;
            m_last  = 1;
            m_show  = 1'b1;
        end else if (acc0 || acc1) begin
            r       = ref_imm(acc1 ? req1_instr : req0_instr);
            m_valid = 1'b1;
            m_imm   = r[31:0];
            m_err   = r[32];
            m_src   = acc1;
            m_tag   = acc1 ? req1_tag : req0_tag;
            m_last  = acc1 ? 1 : 0;
            m_show  = 1'b0;
        end else if (m_valid && res_ready) begin
            m_valid = 1'b0;
            m_show  = 1'b0;
        end
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [8];
        logic [31:0] r;
        ops[0] = 7'h03; ops[1] = 7'h13; ops[2] = 7'h67; ops[3] = 7'h23;
        ops[4] = 7'h63; ops[5] = 7'h37; ops[6] = 7'h33; ops[7] = 7'h6F;
        r = $urandom();
        return {r[31:7], ops[$urandom_range(0, 7)]};
    endfunction

    initial begin
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        res_ready  = 1'b0;
        req0_valid = 1'b1;
        req0_instr = 32'hFFF00093;
        req0_tag   = 4'd3;
        req1_valid = 1'b0;
        req1_instr = 32'h0;
        req1_tag   = 4'd0;
        m_valid    = 1'b0;
        m_show     = 1'b1;
        m_imm      = '0;
        m_src      = 1'b0;
        m_tag      = '0;
        m_err      = 1'b0;
        m_last     = 1;
        acc0       = 1'b0;
        acc1       = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with a pending request.
        repeat (2) begin
            cycle();
            check("rst_res_valid", 32'(res_valid), 32'd0);
            check("rst_res_imm", res_imm, 32'h0);
        end

        // I-type on port 0.
        reset_n   = 1'b1;
        res_ready = 1'b1;
        cycle();
        check("i_valid", 32'(res_valid), 32'd1);
        check("i_imm", res_imm, 32'hFFFFFFFF);
        check("i_src", 32'(res_src), 32'd0);
        check("i_tag", 32'(res_tag), 32'd3);
        check("i_err", 32'(res_err), 32'd0);

        // S and B formats on port 1.
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_tag   = 4'd5;
        req1_instr = 32'hFE112E23;
        cycle();
        check("s_imm", res_imm, 32'hFFFFFFFC);
        check("s_src", 32'(res_src), 32'd1);
        req1_instr = 32'hFE000EE3;
        cycle();
        check("b_imm_neg", res_imm, 32'hFFFFFFFC);
        req1_instr = 32'h00000463;
        cycle();
        check("b_imm_pos", res_imm, 32'h00000008);
        req1_valid = 1'b0;

        // Backpressure with a request pending, then drain+accept together.
        res_ready  = 1'b0;
        req0_valid = 1'b1;
        req0_instr = 32'h00A00113;
        req0_tag   = 4'd7;
        repeat (3) begin
            cycle();
            check("bp_hold_imm", res_imm, 32'h00000008);
            check("bp_hold_src", 32'(res_src), 32'd1);
            check("bp_ready0", 32'(req0_ready), 32'd0);
        end
        res_ready = 1'b1;
        cycle();
        check("bp_valid", 32'(res_valid), 32'd1);
        check("bp_imm", res_imm, 32'd10);
        check("bp_tag", 32'(res_tag), 32'd7);

        // Illegal format, then reset while FULL.
        req0_instr = 32'h00000037;
        req0_tag   = 4'd2;
        cycle();
        check("lui_err", 32'(res_err), 32'd1);
        check("lui_imm", res_imm, 32'h0);
        req0_valid = 1'b0;
        res_ready  = 1'b0;
        reset_n    = 1'b0;
        cycle();
        check("rst_full", 32'(res_valid), 32'd0);

        // Contention right after reset.
        reset_n    = 1'b1;
        res_ready  = 1'b1;
        req0_valid = 1'b1;
        req0_instr = 32'h00500093;
        req0_tag   = 4'd1;
        req1_valid = 1'b1;
        req1_instr = 32'h00812023;
        req1_tag   = 4'd9;
        for (int i = 0; i < 6; i++) begin
            cycle();
`ifdef IMM_ARB_FIXED_PRIO_EN
            check("rr_src", 32'(res_src), 32'd0);
`else
            check("rr_src", 32'(res_src), 32'(i % 2));
`endif
        end

        // Randomized traffic; requesters hold their request until accepted.
        for (int n = 0; n < 3000; n++) begin
            if (!req0_valid || acc0) begin
                req0_valid = ($urandom_range(0, 9) < 6);
                req0_instr = rand_instr();
                req0_tag   = TAG_W'($urandom_range(0, 15));
            end
            if (!req1_valid || acc1) begin
                req1_valid = ($urandom_range(0, 9) < 6);
                req1_instr = rand_instr();
                req1_tag   = TAG_W'($urandom_range(0, 15));
            end
            res_ready = ($urandom_range(0, 9) < 7);
            reset_n   = ($urandom_range(0, 99) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
